// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared stage indices, bus defaults and multi-cycle FSM states
//               for the pipeline control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    localparam int STAGES_DEF    = 6;
    localparam int MC_CYCLES_DEF = 32;
    localparam int CNT_W_DEF     = 32;

    localparam int STAGE_PC  = 0;
    localparam int STAGE_IF  = 1;
    localparam int STAGE_ID  = 2;
    localparam int STAGE_EX  = 3;
    localparam int STAGE_MEM = 4;
    localparam int STAGE_WB  = 5;

    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_BUSY = 2'd1,
        MC_DONE = 2'd2
    } mc_state_e;

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_if
// Description : Request/response bundle between the core stages and pipe_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_if #(
    parameter int STAGES = 6,
    parameter int CNT_W  = 32
) ();

    logic [STAGES-1:0] stallreq;
    logic              mc_start;
    logic              excp_req;
    logic [31:0]       excp_pc;

    logic [STAGES-1:0] stall;
    logic              flush;
    logic [31:0]       new_pc;
    logic              mc_busy;
    logic              mc_done;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output stallreq, mc_start, excp_req, excp_pc,
        input  stall, flush, new_pc, mc_busy, mc_done, stall_cnt, flush_cnt
    );

    modport slave (
        input  stallreq, mc_start, excp_req, excp_pc,
        output stall, flush, new_pc, mc_busy, mc_done, stall_cnt, flush_cnt
    );

endinterface
`default_nettype wire

// File: rtl/pipe_ctrl_mc_seq.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_mc_seq
// Description : Multi-cycle busy sequencer (IDLE/BUSY/DONE) with down-counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl_mc_seq
    import pipe_ctrl_pkg::*;
#(
    parameter int MC_CYCLES = MC_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic abort_i,
    output logic busy_o,
    output logic done_o,
    output logic req_o
);

    localparam int CW = $clog2(MC_CYCLES);

    mc_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MC_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        // An active flush kills the op and masks its outputs in the same cycle.
        if (abort_i) begin
            state_d = MC_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                MC_IDLE: begin
                    if (start_i) begin
                        state_d = MC_BUSY;
                        cnt_d   = CW'(MC_CYCLES - 1);
                    end
                end
                MC_BUSY: begin
                    busy_o = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = MC_DONE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                MC_DONE: begin
                    done_o  = 1'b1;
                    state_d = MC_IDLE;
                end
                default: begin
                    state_d = MC_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        req_o = busy_o;
    end

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Prefix stall merge, multi-cycle sequencer and registered
//               flush/redirect. Perf counters built with PIPE_CTRL_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STAGES    = STAGES_DEF,
    parameter int EX_IDX    = STAGE_EX,
    parameter int MC_CYCLES = MC_CYCLES_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);

    logic              flush_q;
    logic [31:0]       new_pc_q;
    logic              mc_req;
    logic              mc_busy;
    logic              mc_done;
    logic [STAGES-1:0] req_vec;
    logic [STAGES-1:0] stall_raw;
    logic [STAGES-1:0] stall;

    pipe_ctrl_mc_seq #(
        .MC_CYCLES (MC_CYCLES)
    ) u_mc_seq (
        .clk     (clk),
        .rst     (rst),
        .start_i (bus.mc_start),
        .abort_i (flush_q),
        .busy_o  (mc_busy),
        .done_o  (mc_done),
        .req_o   (mc_req)
    );

    assign req_vec = bus.stallreq | (STAGES'(mc_req) << EX_IDX);

    // Stage i holds whenever any stage at or beyond i holds.
    for (genvar i = 0; i < STAGES; i++) begin : g_prefix
        assign stall_raw[i] = |req_vec[STAGES-1:i];
    end

    assign stall = flush_q ? '0 : stall_raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_q  <= 1'b0;
            new_pc_q <= '0;
        end else begin
            flush_q <= bus.excp_req;
            if (bus.excp_req) begin
                new_pc_q <= bus.excp_pc;
            end
        end
    end

    assign bus.stall   = stall;
    assign bus.flush   = flush_q;
    assign bus.new_pc  = new_pc_q;
    assign bus.mc_busy = mc_busy;
    assign bus.mc_done = mc_done;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (|stall) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (flush_q) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
`else
    assign bus.stall_cnt = {CNT_W{1'b0}};
    assign bus.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Directed self-checking bench for pipe_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_PERF_EN
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] EXP_SC = 4'd1;
    localparam logic [CNT_W-1:0] EXP_FC = 4'd3;
`else
    localparam int CNT_W = 32;
    localparam logic [CNT_W-1:0] EXP_SC = '0;
    localparam logic [CNT_W-1:0] EXP_FC = '0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl_if #(.STAGES(6), .CNT_W(CNT_W)) ifc ();

    pipe_ctrl #(
        .STAGES    (6),
        .EX_IDX    (3),
        .MC_CYCLES (32),
        .CNT_W     (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        ifc.stallreq = '0;
        ifc.mc_start = 1'b0;
        ifc.excp_req = 1'b0;
        ifc.excp_pc  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++;
        if (ifc.stall !== 6'b0) begin
            errors++; $display("FAIL reset_stall got %b exp %b", ifc.stall, 6'b0);
        end
        checks++;
        if (ifc.flush !== 1'b0 || ifc.new_pc !== 32'h0) begin
            errors++; $display("FAIL reset_flush got %b/%h exp 0/00000000", ifc.flush, ifc.new_pc);
        end
        checks++;
        if (ifc.mc_busy !== 1'b0 || ifc.mc_done !== 1'b0) begin
            errors++; $display("FAIL reset_mc got busy %b done %b exp 0/0", ifc.mc_busy, ifc.mc_done);
        end
        checks++;
        if (ifc.stall_cnt !== '0 || ifc.flush_cnt !== '0) begin
            errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", ifc.stall_cnt, ifc.flush_cnt);
        end
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_prefix();
        logic [5:0] reqs [6] = '{6'b000100, 6'b010100, 6'b000000, 6'b100000, 6'b000001, 6'b001010};
        logic [5:0] exps [6] = '{6'b000111, 6'b011111, 6'b000000, 6'b111111, 6'b000001, 6'b001111};
        for (int i = 0; i < 6; i++) begin
            ifc.stallreq = reqs[i];
            @(negedge clk);
            checks++;
            if (ifc.stall !== exps[i]) begin
                errors++; $display("FAIL prefix[%0d] got %b exp %b", i, ifc.stall, exps[i]);
            end
            next_cycle();
        end
        ifc.stallreq = '0;
    endtask

    task automatic test_multicycle();
        logic [5:0] exp_stall;
        logic       exp_busy;
        logic       exp_done;
        ifc.mc_start = 1'b1;
        next_cycle();
        for (int k = 1; k <= 34; k++) begin
            ifc.mc_start = (k == 5 || k == 33);
            ifc.stallreq = (k == 10) ? 6'b010000 : (k == 11) ? 6'b000001 : 6'b000000;
            @(negedge clk);
            exp_busy  = (k <= 32);
            exp_done  = (k == 33);
            exp_stall = exp_busy ? ((k == 10) ? 6'b011111 : 6'b001111) : 6'b000000;
            checks++;
            if (ifc.stall !== exp_stall || ifc.mc_busy !== exp_busy || ifc.mc_done !== exp_done) begin
                errors++;
                $display("FAIL mc_seq k=%0d got stall %b busy %b done %b exp %b %b %b",
                         k, ifc.stall, ifc.mc_busy, ifc.mc_done, exp_stall, exp_busy, exp_done);
            end
            next_cycle();
        end
        drive_idle();
    endtask

    task automatic test_flush();
        logic [31:0] pcs [3] = '{32'h8000_0180, 32'h8000_0200, 32'hBFC0_0000};
        ifc.stallreq = 6'b111111;
        ifc.excp_req = 1'b1;
        ifc.excp_pc  = 32'hBFC0_0380;
        @(negedge clk);
        checks++;
        if (ifc.stall !== 6'b111111 || ifc.flush !== 1'b0) begin
            errors++; $display("FAIL flush_pre got stall %b flush %b exp 111111 0", ifc.stall, ifc.flush);
        end
        next_cycle();
        ifc.excp_req = 1'b0;
        ifc.excp_pc  = 32'h1234_5678;
        @(negedge clk);
        checks++;
        if (ifc.flush !== 1'b1 || ifc.new_pc !== 32'hBFC0_0380 || ifc.stall !== 6'b0) begin
            errors++;
            $display("FAIL flush_hit got flush %b pc %h stall %b exp 1 bfc00380 000000",
                     ifc.flush, ifc.new_pc, ifc.stall);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (ifc.flush !== 1'b0 || ifc.new_pc !== 32'hBFC0_0380 || ifc.stall !== 6'b111111) begin
            errors++;
            $display("FAIL flush_post got flush %b pc %h stall %b exp 0 bfc00380 111111",
                     ifc.flush, ifc.new_pc, ifc.stall);
        end
        ifc.stallreq = '0;
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            ifc.excp_req = (i < 3);
            ifc.excp_pc  = (i < 3) ? pcs[i] : 32'h0;
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (ifc.flush !== 1'b1 || ifc.new_pc !== pcs[i-1]) begin
                    errors++;
                    $display("FAIL flush_b2b[%0d] got flush %b pc %h exp 1 %h", i, ifc.flush, ifc.new_pc, pcs[i-1]);
                end
            end
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if (ifc.flush !== 1'b0 || ifc.new_pc !== 32'hBFC0_0000) begin
            errors++; $display("FAIL flush_b2b_end got flush %b pc %h exp 0 bfc00000", ifc.flush, ifc.new_pc);
        end
        next_cycle();
        drive_idle();
    endtask

    task automatic test_flush_abort();
        bit bad = 1'b0;
        ifc.mc_start = 1'b1;
        next_cycle();
        ifc.mc_start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            ifc.excp_req = (k == 10);
            ifc.excp_pc  = (k == 10) ? 32'h8000_0180 : 32'h0;
            @(negedge clk);
            if (k == 10) begin
                checks++;
                if (ifc.mc_busy !== 1'b1 || ifc.stall !== 6'b001111) begin
                    errors++; $display("FAIL abort_pre got busy %b stall %b exp 1 001111", ifc.mc_busy, ifc.stall);
                end
            end
            if (k == 11) begin
                checks++;
                if (ifc.flush !== 1'b1 || ifc.mc_busy !== 1'b0 || ifc.stall !== 6'b0) begin
                    errors++;
                    $display("FAIL abort_hit got flush %b busy %b stall %b exp 1 0 000000",
                             ifc.flush, ifc.mc_busy, ifc.stall);
                end
            end
            if (k >= 11 && (ifc.mc_busy !== 1'b0 || ifc.mc_done !== 1'b0)) bad = 1'b1;
            next_cycle();
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++; $display("FAIL abort_quiet got activity %b exp %b", bad, 1'b0);
        end
        bad = 1'b0;
        ifc.mc_start = 1'b1;
        ifc.excp_req = 1'b1;
        ifc.excp_pc  = 32'h8000_0180;
        next_cycle();
        drive_idle();
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if (ifc.flush !== 1'b1 || ifc.new_pc !== 32'h8000_0180) begin
                    errors++; $display("FAIL same_cyc_flush got %b %h exp 1 80000180", ifc.flush, ifc.new_pc);
                end
            end
            if (ifc.mc_busy !== 1'b0 || ifc.mc_done !== 1'b0 || ifc.stall !== 6'b0) bad = 1'b1;
            next_cycle();
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++; $display("FAIL same_cyc_discard got activity %b exp %b", bad, 1'b0);
        end
    endtask

    task automatic test_rst_mid();
        logic exp_busy;
        logic exp_done;
        ifc.mc_start = 1'b1;
        next_cycle();
        for (int k = 1; k <= 43; k++) begin
            rst          = (k == 5);
            ifc.mc_start = (k == 8);
            @(negedge clk);
            exp_busy = (k <= 5) || (k >= 9 && k <= 40);
            exp_done = (k == 41);
            checks++;
            if (ifc.mc_busy !== exp_busy || ifc.mc_done !== exp_done ||
                ifc.stall !== (exp_busy ? 6'b001111 : 6'b000000)) begin
                errors++;
                $display("FAIL rst_mid k=%0d got busy %b done %b stall %b exp %b %b",
                         k, ifc.mc_busy, ifc.mc_done, ifc.stall, exp_busy, exp_done);
            end
            if (k == 6) begin
                checks++;
                if (ifc.flush !== 1'b0 || ifc.new_pc !== 32'h0) begin
                    errors++; $display("FAIL rst_mid_pc got %b %h exp 0 00000000", ifc.flush, ifc.new_pc);
                end
            end
            next_cycle();
        end
        rst = 1'b0;
        drive_idle();
    endtask

    task automatic test_perf();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            ifc.stallreq = 6'b000001;
            next_cycle();
        end
        ifc.stallreq = '0;
        @(negedge clk);
        checks++;
        if (ifc.stall_cnt !== EXP_SC) begin
            errors++; $display("FAIL perf_stall got %0d exp %0d", ifc.stall_cnt, EXP_SC);
        end
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            ifc.excp_req = 1'b1;
            ifc.excp_pc  = 32'h100 + 32'(i);
            next_cycle();
        end
        ifc.excp_req = 1'b0;
        next_cycle();
        @(negedge clk);
        checks++;
        if (ifc.flush_cnt !== EXP_FC || ifc.stall_cnt !== EXP_SC) begin
            errors++;
            $display("FAIL perf_flush got %0d/%0d exp %0d/%0d", ifc.flush_cnt, ifc.stall_cnt, EXP_FC, EXP_SC);
        end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_prefix();
        test_multicycle();
        test_flush();
        test_flush_abort();
        test_rst_mid();
        test_perf();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline control unit for the five-stage MIPS core; the next generation of the fixed all-zero stall controller. It merges per-stage stall requests into a prefix stall vector, drives a built-in multi-cycle busy sequencer for EX-stage iterative ops (divide), and issues registered one-cycle flushes with a redirect PC for exceptions/eret. It sits beside the stage chain at core top and feeds the `stall` bus of IF/ID/EX/MEM/WB.

## Interface
- STAGES, 6, stall bus width; bit 0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM, 5 = WB
- EX_IDX, 3, stall-bus index of the stage that owns the multi-cycle unit
- MC_CYCLES, 32, busy cycles per multi-cycle op (≥2)
- CNT_W, 32, perf-counter width

Ports:
- clk  in  1  core clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- stallreq  in  STAGES  bit k = stage k requests a hold this cycle
- mc_start  in  1  EX issues a multi-cycle op (single-cycle pulse)
- excp_req  in  1  exception/eret taken in MEM
- excp_pc  in  32  redirect target, sampled with excp_req
- stall  out  STAGES  bit i = stage i holds
- flush  out  1  kill all in-flight instructions, one cycle
- new_pc  out  32  redirect PC, valid while flush = 1
- mc_busy  out  1  multi-cycle unit running
- mc_done  out  1  one-cycle pulse, result valid in EX
- stall_cnt  out  CNT_W  cycles with stall ≠ 0 (PIPE_CTRL_PERF_EN only)
- flush_cnt  out  CNT_W  flushes issued (PIPE_CTRL_PERF_EN only)

## Operation
- Prefix rule: k = highest set request index (stallreq or internal MC request at EX_IDX); stall[0..k] = 1, stall[k+1..] = 0. No request → stall = 0.
- MC FSM: IDLE, BUSY, DONE.
  - IDLE: mc_start → BUSY, counter = MC_CYCLES-1.
  - BUSY: counter decrements; internal request at EX_IDX asserted; counter = 0 → DONE.
  - DONE: mc_done = 1, internal request dropped, → IDLE.
  - mc_start in BUSY/DONE ignored.
- Flush: excp_req registers flush = 1 and new_pc = excp_pc for exactly the next cycle. On excp_req in back-to-back cycles, one flush per cycle, each using its own excp_pc.
- Flush priority: while flush = 1, stall forced to 0 and FSM forced to IDLE (aborts BUSY, suppresses mc_done). excp_req and mc_start in the same cycle: the flush wins in the following cycle and the op is discarded.
- new_pc holds its last value when flush = 0.
- Counter arithmetic modulo 2^CNT_W, wraps silently.

## Timing
- stall: combinational from stallreq and registered FSM state, same cycle.
- mc_start at cycle t: stall[0..EX_IDX] high t+1 … t+MC_CYCLES; mc_done at t+MC_CYCLES+1 with stall released that cycle. Total op occupancy MC_CYCLES+1 cycles.
- excp_req at t → flush, new_pc at t+1; flush low at t+2 unless re-requested.
- Reset: stall = 0, flush = 0, new_pc = 0, mc_busy = 0, mc_done = 0, FSM IDLE, counter 0, stall_cnt = flush_cnt = 0. rst mid-op aborts immediately; no mc_done is emitted.

## Configuration
- PIPE_CTRL_PERF_EN defined: stall_cnt increments every cycle stall ≠ 0; flush_cnt increments every cycle flush = 1; both cleared by rst.
- Undefined: counters absent; stall_cnt and flush_cnt ports tied to 0; no extra flops.

## Structure
- Shared package (lib/defines.vh): StallBus width, stage-index constants (PC/IF/ID/EX/MEM/WB), MC FSM state encodings.
- One sub-module: `mc_seq` (multi-cycle FSM + down-counter, outputs mc_busy/mc_done/internal request). Prefix encoder, flush register and perf counters stay in pipe_ctrl.

## Test plan
- stallreq = 6'b000100 (ID) → stall = 6'b000111; stallreq = 6'b010100 → stall = 6'b011111 same cycle.
- mc_start at t, MC_CYCLES = 32 → stall = 6'b001111 for t+1..t+32, mc_done = 1 only at t+33, stall = 0 at t+33.
- excp_req at t with excp_pc = 0xBFC00380 → flush = 1, new_pc = 0xBFC00380 at t+1 only; stall = 0 that cycle despite stallreq = 6'b111111.
- mc_start at t, excp_req at t+10 → flush at t+11, mc_busy = 0 from t+11, no mc_done ever.
- rst asserted at t+5 of a BUSY op → all outputs at reset values from t+6; mc_start at t+8 restarts a full MC_CYCLES sequence.
- PIPE_CTRL_PERF_EN, CNT_W = 4: 17 stalled cycles → stall_cnt = 1 (wrap); 3 flushes → flush_cnt = 3.
